// File: rtl/dds_freq_meter.sv
// dds_freq_meter: measures NPER periods of an offset-binary sample stream
// and converts the cycle count into the equivalent DDS frequency word,
// FW = round(2^N * NPER / cycles), using a serial restoring divider.
module dds_freq_meter #(
   parameter int unsigned W         = 10,
   parameter int unsigned N         = 24,
   parameter int unsigned NPER_LOG2 = 4,
   parameter int unsigned HYST      = 32,
   parameter int unsigned CNT_W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] q_sin,
   output logic [N-1:0] freq_word,
   output logic         fw_valid,
   output logic         busy,
   output logic         timeout
);

   localparam int unsigned MID    = 1 << (W - 1);
   localparam int unsigned QB     = N + NPER_LOG2 + 1;
   localparam int unsigned NUM_W  = ((QB > CNT_W) ? QB : CNT_W) + 1;
   localparam int unsigned STEP_W = $clog2(QB);

   localparam logic [W-1:0]      MID_V     = W'(MID);
   localparam logic [W-1:0]      LO_TH     = W'(MID - HYST);
   localparam logic [W-1:0]      HI_TH     = W'(MID + HYST);
   localparam logic [CNT_W-1:0]  CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(QB - 1);

   typedef enum logic [1:0] {SYNC, COUNT, DIV, DONE} state_t;

   state_t state, next_state;

   logic [W-1:0]         s;
   logic                 armed;
   logic                 evt;
   logic                 last_evt;
   logic [CNT_W-1:0]     cnt;
   logic [NPER_LOG2-1:0] pcnt;
   logic [CNT_W-1:0]     cycles;
   logic [NUM_W-1:0]     num;
   logic [CNT_W-1:0]     num_hi;
   logic [CNT_W-1:0]     den;
   logic [CNT_W-1:0]     rem;
   logic [CNT_W-1:0]     rem_nx;
   logic [QB-1:0]        sh;
   logic [CNT_W:0]       trial;
   logic                 ge;
   logic [N-1:0]         q_final;
   logic [STEP_W-1:0]    step;

   logic start_cnt;
   logic term;
   logic to_fire;
   logic div_last;

   // Rising crossing: armed below the band, fires once on reaching above it
   assign evt      = armed && (s >= HI_TH);
   assign last_evt = evt && (pcnt == '1);

   // Cycle count and rounded numerator prepared for the divider load
   assign cycles = cnt + CNT_W'(1);
   assign num    = (NUM_W'(1) << (N + NPER_LOG2)) + NUM_W'(cycles >> 1);
   assign num_hi = CNT_W'(num >> QB);

   // One restoring-divide step; the partial remainder always stays below den
   assign trial   = {rem, sh[QB-1]};
   assign ge      = (trial >= {1'b0, den});
   assign rem_nx  = CNT_W'(ge ? (trial - {1'b0, den}) : trial);
   assign q_final = {sh[N-2:0], ge};

   // Input register and hysteresis arming flag
   always_ff @(posedge clk) begin
      if (rst) begin
         s     <= MID_V;
         armed <= 1'b0;
      end else begin
         s <= q_sin;
         if (evt)
            armed <= 1'b0;
         else if (s < LO_TH)
            armed <= 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= SYNC;
      else
         state <= next_state;
   end

   // FSM next-state and control strobes; an event always beats a timeout
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      start_cnt  = 1'b0;
      term       = 1'b0;
      to_fire    = 1'b0;
      div_last   = 1'b0;
      case (state)
         SYNC: begin
            if (evt) begin
               start_cnt  = 1'b1;
               next_state = COUNT;
            end else if (cnt == CNT_LAST) begin
               to_fire = 1'b1;
            end
         end
         COUNT: begin
            busy = 1'b1;
            if (last_evt) begin
               term       = 1'b1;
               next_state = DIV;
            end else if ((cnt >= CNT_LAST) && !evt) begin
               to_fire    = 1'b1;
               next_state = SYNC;
            end
         end
         DIV: begin
            busy = 1'b1;
            if (step == STEP_LAST) begin
               div_last   = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = SYNC;
         end
         default: begin
            next_state = SYNC;
         end
      endcase
   end

   // Counters, divider datapath and registered result/pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         pcnt      <= '0;
         den       <= '0;
         rem       <= '0;
         sh        <= '0;
         step      <= '0;
         freq_word <= '0;
         fw_valid  <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         fw_valid <= 1'b0;
         timeout  <= to_fire;
         case (state)
            SYNC: begin
               if (start_cnt) begin
                  cnt  <= '0;
                  pcnt <= '0;
               end else if (to_fire) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            COUNT: begin
               if (term) begin
                  // Numerator split: high part seeds the remainder, low
                  // QB bits shift in one per step and become the quotient.
                  den  <= cycles;
                  rem  <= num_hi;
                  sh   <= num[QB-1:0];
                  step <= '0;
                  cnt  <= '0;
                  pcnt <= '0;
               end else if (to_fire) begin
                  cnt  <= '0;
                  pcnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (evt)
                     pcnt <= pcnt + NPER_LOG2'(1);
               end
            end
            DIV: begin
               rem  <= rem_nx;
               sh   <= {sh[QB-2:0], ge};
               step <= step + STEP_W'(1);
               if (div_last) begin
                  freq_word <= q_final;
                  fw_valid  <= 1'b1;
               end
            end
            DONE: begin
               cnt  <= '0;
               pcnt <= '0;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule
